pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the five-stage pipeline: generates the load and flush (synchronous clear) for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It tracks instruction- and data-memory completion, inserts load-use bubbles and squashes wrong-path instructions on taken branches or jumps. It sits beside the datapath and is the only driver of the stage registers' load and reset inputs.

---
 rtl/pipe_ctrl_pkg.sv | 34 +++
 rtl/pipeline_hazard_ctrl_if.sv | 9 +
 rtl/load_use_detect.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 79 +++++++
 tb/tb_pipeline_hazard_ctrl.sv | 132 +++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;
  localparam int REG_IDX_W = 5;
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } stage_ctrl_t;
  typedef enum logic [1:0] {ADV_NONE, ADV_NORMAL, ADV_BRANCH, ADV_BUBBLE} adv_cause_t;
  localparam stage_ctrl_t RESET_CTRL = stage_ctrl_t'(9'b0_0000_1111);
  function automatic stage_ctrl_t ctrl_of(input adv_cause_t c, input logic rst_active);
    stage_ctrl_t s;
    logic fwd;
    logic go;
    fwd = (c == ADV_NORMAL) || (c == ADV_BRANCH);
    go = c != ADV_NONE;
    s.load_pc = fwd;
    s.load_if_id = fwd;
    s.load_id_ex = go;
    s.load_ex_mem = go;
    s.load_mem_wb = go;
    s.flush_if_id = c == ADV_BRANCH;
    s.flush_id_ex = (c == ADV_BRANCH) || (c == ADV_BUBBLE);
    s.flush_ex_mem = 1'b0;
    s.flush_mem_wb = 1'b0;
    return rst_active ? RESET_CTRL : s;
  endfunction
endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: instruction/data memory handshake seen by the hazard controller.
interface pipeline_hazard_ctrl_if;
  logic imem_read;
  logic imem_resp;
  logic dmem_req;
  logic dmem_resp;
  modport master (output imem_read, input imem_resp, dmem_req, dmem_resp);
  modport slave (input imem_read, output imem_resp, dmem_req, dmem_resp);
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load still in EX.
module load_use_detect import pipe_ctrl_pkg::*; (
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_valid,
  output logic                 load_use
);
  assign load_use = ex_valid & ex_is_load & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage-register load/flush sequencer with memory-wait, load-use and branch handling.
// Define PIPELINE_PERF_CNT_EN to build the performance counters; otherwise perf_* read 0.
module pipeline_hazard_ctrl import pipe_ctrl_pkg::*; (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_hazard_ctrl_if.master mem,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_is_load,
  input  logic                 ex_valid,
  input  logic                 br_taken,
  output logic                 load_pc,
  output logic                 load_if_id,
  output logic                 load_id_ex,
  output logic                 load_ex_mem,
  output logic                 load_mem_wb,
  output logic                 flush_if_id,
  output logic                 flush_id_ex,
  output logic                 flush_ex_mem,
  output logic                 flush_mem_wb,
  output logic [31:0]          perf_cycles,
  output logic [31:0]          perf_stalls,
  output logic [31:0]          perf_bubbles,
  output logic [31:0]          perf_flushes
);
  logic fetch_done, dmem_done, imem_ok, dmem_ok, advance, load_use;
  adv_cause_t cause;
  stage_ctrl_t ctrl;
  load_use_detect u_lud (
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .load_use(load_use)
  );
  assign imem_ok = mem.imem_resp | fetch_done;
  assign dmem_ok = !mem.dmem_req | mem.dmem_resp | dmem_done;
  assign advance = imem_ok & dmem_ok;
  assign mem.imem_read = reset_n & !fetch_done;
  // A taken branch outranks load-use: the dependent ID instruction is on the wrong path.
  always_comb begin
    cause = !advance ? ADV_NONE : br_taken ? ADV_BRANCH : load_use ? ADV_BUBBLE : ADV_NORMAL;
    ctrl = ctrl_of(cause, !reset_n);
  end
  assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
          flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb} = ctrl;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fetch_done <= 1'b0;
      dmem_done <= 1'b0;
    end else begin
      fetch_done <= !advance & (fetch_done | mem.imem_resp);
      dmem_done <= !advance & (dmem_done | mem.dmem_resp);
    end
`ifdef PIPELINE_PERF_CNT_EN
  logic [31:0] cyc_q, stl_q, bub_q, fls_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cyc_q <= '0;
      stl_q <= '0;
      bub_q <= '0;
      fls_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      stl_q <= stl_q + 32'(cause == ADV_NONE);
      bub_q <= bub_q + 32'(cause == ADV_BUBBLE);
      fls_q <= fls_q + 32'(cause == ADV_BRANCH);
    end
  assign perf_cycles = cyc_q;
  assign perf_stalls = stl_q;
  assign perf_bubbles = bub_q;
  assign perf_flushes = fls_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
  assign perf_bubbles = '0;
  assign perf_flushes = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors plus multi-cycle sequences, expectations queued per cycle.
module tb_pipeline_hazard_ctrl;
  localparam logic [8:0] NRM = 9'b11111_0000;
  localparam logic [8:0] BRC = 9'b11111_1100;
  localparam logic [8:0] BUB = 9'b00111_0100;
  localparam logic [8:0] STL = 9'b00000_0000;
  localparam logic [8:0] RST = 9'b00000_1111;
  typedef struct {
    logic rst_n, im, dq, dr;
    logic [4:0] rs1, rs2;
    logic u1, u2;
    logic [4:0] rd;
    logic ld, vld, br;
    logic [8:0] ctrl;
    logic ird;
  } vec_t;
  typedef struct {logic [8:0] ctrl; logic ird;} exp_t;
  logic clk = 0, reset_n = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_is_load = 0, ex_valid = 0, br_taken = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic [31:0] perf_cycles, perf_stalls, perf_bubbles, perf_flushes;
  logic [31:0] m_cyc = 0, m_stl = 0, m_bub = 0, m_fls = 0;
  int checks = 0, failures = 0;
  exp_t exp_q[$];
  vec_t tbl[14];
  pipeline_hazard_ctrl_if mif();
  pipeline_hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n), .mem(mif),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .br_taken(br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
    .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic rst_n, logic im, logic dq, logic dr, logic [4:0] rs1, logic [4:0] rs2,
                              logic u1, logic u2, logic [4:0] rd, logic ld, logic vld, logic br,
                              logic [8:0] ctrl, logic ird);
    vec_t v;
    v.rst_n = rst_n; v.im = im; v.dq = dq; v.dr = dr; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld; v.vld = vld; v.br = br;
    v.ctrl = ctrl; v.ird = ird;
    return v;
  endfunction
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  task automatic check(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      cmp({name, "_queue"}, 0, 1);
      return;
    end
    e = exp_q.pop_front();
    if (!reset_n) begin
      m_cyc = 0; m_stl = 0; m_bub = 0; m_fls = 0;
    end
    cmp({name, "_ctrl"}, 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                              flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}), 32'(e.ctrl));
    cmp({name, "_imem_read"}, 32'(mif.imem_read), 32'(e.ird));
    cmp({name, "_perf_cycles"}, perf_cycles, m_cyc);
    cmp({name, "_perf_stalls"}, perf_stalls, m_stl);
    cmp({name, "_perf_bubbles"}, perf_bubbles, m_bub);
    cmp({name, "_perf_flushes"}, perf_flushes, m_fls);
`ifdef PIPELINE_PERF_CNT_EN
    if (reset_n) begin
      m_cyc++;
      if (e.ctrl == STL) m_stl++;
      if (e.ctrl == BUB) m_bub++;
      if (e.ctrl == BRC) m_fls++;
    end
`endif
  endtask
  task automatic step(input vec_t v, input string name);
    @(posedge clk);
    #1;
    reset_n = v.rst_n; mif.imem_resp = v.im; mif.dmem_req = v.dq; mif.dmem_resp = v.dr;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    ex_rd = v.rd; ex_is_load = v.ld; ex_valid = v.vld; br_taken = v.br;
    exp_q.push_back('{ctrl: v.ctrl, ird: v.ird});
    @(negedge clk);
    check(name);
  endtask
  initial begin
    mif.imem_resp = 0; mif.dmem_req = 0; mif.dmem_resp = 0;
    tbl[0]  = mk(1, 1, 0, 0, 1, 2, 1, 1, 3, 1, 1, 0, NRM, 1);
    tbl[1]  = mk(1, 1, 0, 0, 1, 5, 0, 1, 5, 1, 1, 0, BUB, 1);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, NRM, 1);
    tbl[3]  = mk(1, 1, 0, 0, 7, 2, 1, 0, 7, 1, 1, 0, BUB, 1);
    tbl[4]  = mk(1, 1, 0, 0, 7, 2, 0, 1, 7, 1, 1, 0, NRM, 1);
    tbl[5]  = mk(1, 1, 0, 0, 7, 7, 1, 1, 7, 0, 1, 0, NRM, 1);
    tbl[6]  = mk(1, 1, 0, 0, 7, 7, 1, 1, 7, 1, 0, 0, NRM, 1);
    tbl[7]  = mk(1, 1, 0, 0, 1, 2, 1, 1, 3, 0, 1, 1, BRC, 1);
    tbl[8]  = mk(1, 1, 0, 0, 1, 5, 0, 1, 5, 1, 1, 1, BRC, 1);
    tbl[9]  = mk(1, 1, 1, 1, 1, 2, 1, 1, 3, 0, 1, 0, NRM, 1);
    tbl[10] = mk(1, 0, 0, 0, 1, 2, 1, 1, 3, 0, 1, 0, STL, 1);
    tbl[11] = mk(1, 0, 1, 0, 1, 2, 1, 1, 3, 0, 1, 0, STL, 1);
    tbl[12] = mk(1, 0, 0, 0, 5, 2, 1, 1, 5, 1, 1, 1, STL, 1);
    tbl[13] = mk(1, 1, 1, 1, 9, 2, 1, 0, 9, 1, 1, 0, BUB, 1);
    for (int i = 0; i < 3; i++) step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0), "reset_hold");
    for (int i = 0; i < 3; i++) step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1), "post_reset");
    for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("tbl%0d", i));
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "imem_late");
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1), "imem_arrive");
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "dm_c1");
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0), "dm_c2");
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 0), "dm_c3");
    step(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0), "dm_c4");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "dm_c5");
    step(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "dd_set");
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "dd_hold");
    reset_n = 0;
    #1;
    exp_q.push_back('{ctrl: RST, ird: 1'b0});
    check("async_reset");
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST, 0), "async_reset_hold");
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, STL, 1), "dd_cleared");
    step(mk(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0), "dd_recover");
    step(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1), "final");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
